// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - round-timing controller: countdown, timed play window, score
module game_sequencer #(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int COUNTDOWN_SEC = 3,
   parameter int GAME_SEC      = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       abort,
   input  logic       hit,
   output logic       countdown_start,
   output logic       game_start,
   output logic       game_finish,
   output logic [3:0] countdown_value,
   output logic [7:0] time_left,
   output logic [7:0] score
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAYING   = 2'd2,
      ST_FINISHED  = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [PW-1:0] presc;
   logic          start_q, hit_q;
   logic          tick, start_rise, hit_rise;
   logic [3:0]    cd_next;
   logic [7:0]    tl_next, score_next;

   assign start_rise = start_btn & ~start_q;
   assign hit_rise   = hit & ~hit_q;
   assign tick       = (presc == PW'(TICKS_PER_SEC - 1));

   assign countdown_start = (state == ST_COUNTDOWN);
   assign game_start      = (state == ST_PLAYING);
   assign game_finish     = (state == ST_FINISHED);

   always_comb begin
      state_next = state;
      cd_next    = countdown_value;
      tl_next    = time_left;
      score_next = score;
      if (abort) begin
         state_next = ST_IDLE;
         cd_next    = 4'd0;
         tl_next    = 8'd0;
      end else begin
         case (state)
            ST_IDLE, ST_FINISHED: begin
               if (start_rise) begin
                  state_next = ST_COUNTDOWN;
                  cd_next    = 4'(COUNTDOWN_SEC);
                  score_next = 8'd0;
               end
            end
            ST_COUNTDOWN: begin
               if (tick) begin
                  cd_next = countdown_value - 4'd1;
                  if (countdown_value == 4'd1) begin
                     state_next = ST_PLAYING;
                     tl_next    = 8'(GAME_SEC);
                  end
               end
            end
            ST_PLAYING: begin
               // A hit on the closing tick edge still counts toward this round.
               if (hit_rise && score != 8'hFF)
                  score_next = score + 8'd1;
               if (tick) begin
                  tl_next = time_left - 8'd1;
                  if (time_left == 8'd1)
                     state_next = ST_FINISHED;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         presc           <= '0;
         start_q         <= 1'b0;
         hit_q           <= 1'b0;
         countdown_value <= 4'd0;
         time_left       <= 8'd0;
         score           <= 8'd0;
      end else begin
         state           <= state_next;
         start_q         <= start_btn;
         hit_q           <= hit;
         countdown_value <= cd_next;
         time_left       <= tl_next;
         score           <= score_next;
         // Restart on every state entry so each phase gets whole seconds.
         if (state_next != state || tick ||
             (state != ST_COUNTDOWN && state != ST_PLAYING))
            presc <= '0;
         else
            presc <= presc + 1'b1;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_btn, abort, hit;
   logic       countdown_start, game_start, game_finish;
   logic [3:0] countdown_value;
   logic [7:0] time_left, score;

   logic       start2, abort2, hit2;
   logic       cs2, gs2, gf2;
   logic [3:0] cv2;
   logic [7:0] tl2, score2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   game_sequencer #(.TICKS_PER_SEC(4), .COUNTDOWN_SEC(3), .GAME_SEC(5)) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .abort(abort), .hit(hit),
      .countdown_start(countdown_start), .game_start(game_start),
      .game_finish(game_finish), .countdown_value(countdown_value),
      .time_left(time_left), .score(score)
   );

   game_sequencer #(.TICKS_PER_SEC(4), .COUNTDOWN_SEC(3), .GAME_SEC(255)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start_btn(start2), .abort(abort2), .hit(hit2),
      .countdown_start(cs2), .game_start(gs2), .game_finish(gf2),
      .countdown_value(cv2), .time_left(tl2), .score(score2)
   );

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start_btn = 1'b0; abort = 1'b0; hit = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; hit2 = 1'b0;
      #1;
      check("rst_cs", countdown_start, 0);
      check("rst_gs", game_start, 0);
      check("rst_gf", game_finish, 0);
      check("rst_cv", countdown_value, 0);
      check("rst_tl", time_left, 0);
      check("rst_score", score, 0);
      step(2);
      rst_n = 1'b1;
      step(8);
      check("idle_cs", countdown_start, 0);

      // Round 1: start held high for the whole round
      start_btn = 1'b1;
      step(1);
      check("cd_enter_cs", countdown_start, 1);
      check("cd_enter_cv", countdown_value, 3);
      check("cd_enter_gs", game_start, 0);
      hit = 1'b1; step(1); hit = 1'b0; step(2);
      check("cd_hold_cv", countdown_value, 3);
      check("cd_hit_ignored", score, 0);
      step(1);
      check("cd_cv2", countdown_value, 2);
      step(4);
      check("cd_cv1", countdown_value, 1);
      step(3);
      check("cd_last_cs", countdown_start, 1);
      step(1);
      check("play_gs", game_start, 1);
      check("play_cs", countdown_start, 0);
      check("play_tl", time_left, 5);
      check("play_cv", countdown_value, 0);

      for (int i = 0; i < 3; i++) begin
         hit = 1'b1; step(1); hit = 1'b0; step(1);
      end
      check("play_score3", score, 3);
      check("play_tl4", time_left, 4);
      step(13);
      check("play_tl1", time_left, 1);
      check("play_last_gs", game_start, 1);
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      check("fin_gf", game_finish, 1);
      check("fin_gs", game_start, 0);
      check("fin_tl", time_left, 0);
      check("fin_score_final_hit", score, 4);

      hit = 1'b1; step(1); hit = 1'b0; step(10);
      check("fin_hold_gf", game_finish, 1);
      check("fin_hold_cs", countdown_start, 0);
      check("fin_hit_ignored", score, 4);

      // Re-press from FINISHED
      start_btn = 1'b0; step(1);
      start_btn = 1'b1; step(1);
      check("repress_cs", countdown_start, 1);
      check("repress_gf", game_finish, 0);
      check("repress_score", score, 0);
      check("repress_cv", countdown_value, 3);

      // Abort mid-PLAYING
      step(12);
      check("r2_play_gs", game_start, 1);
      hit = 1'b1; step(1); hit = 1'b0; step(1);
      check("r2_score", score, 1);
      abort = 1'b1; step(1); abort = 1'b0;
      check("abort_gs", game_start, 0);
      check("abort_cs", countdown_start, 0);
      check("abort_gf", game_finish, 0);
      check("abort_tl", time_left, 0);
      check("abort_score_held", score, 1);

      // Reset mid-COUNTDOWN, observed before any clock edge
      start_btn = 1'b0; step(1);
      start_btn = 1'b1; step(1);
      check("r3_cs", countdown_start, 1);
      step(2);
      rst_n = 1'b0;
      #1;
      check("async_rst_cs", countdown_start, 0);
      check("async_rst_cv", countdown_value, 0);
      check("async_rst_score", score, 0);
      step(1);
      rst_n = 1'b1;
      start_btn = 1'b0;
      step(2);

      // Score saturation with a 255-second play window
      start2 = 1'b1; step(1); start2 = 1'b0;
      step(12);
      check("sat_gs", gs2, 1);
      for (int i = 0; i < 300; i++) begin
         hit2 = 1'b1; step(1); hit2 = 1'b0; step(1);
      end
      check("sat_score", score2, 255);
      check("sat_still_playing", gs2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
